// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with one outstanding request, skid entry and redirect flush
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF_i,
   input  logic        PCSrcE_i,
   input  logic [31:0] PCTargetE_i,
   output logic        IMemReq_o,
   output logic [31:0] IMemAddr_o,
   input  logic        IMemReady_i,
   input  logic        IMemRValid_i,
   input  logic [31:0] IMemRData_i,
   output logic [31:0] InstructionF_o,
   output logic [31:0] PCF_o,
   output logic [31:0] PCPlus4F_o,
   output logic        ValidF_o
);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t      state;
   logic [31:0] fpc;
   logic [31:0] req_pc;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;
   logic        skid_v;
   logic        rsp_take;
   logic        to_skid;
   logic        req_ok;
   logic        req_fire;

   assign rsp_take = IMemRValid_i && (state == WAIT) && !PCSrcE_i && !rst;
   // A response landing in the skid leaves no room for another one, so hold the next request back.
   assign to_skid  = rsp_take && ValidF_o && StallF_i;
   assign req_ok   = ((state == IDLE) || ((state == WAIT) && IMemRValid_i)) &&
                     !skid_v && !to_skid && !PCSrcE_i && !rst;
   assign req_fire = req_ok && IMemReady_i;

   assign IMemReq_o  = req_ok;
   assign IMemAddr_o = fpc;

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc            <= RESET_PC;
         req_pc         <= RESET_PC;
         // A request still in flight when reset hits must have its response swallowed later.
         state          <= (((state == WAIT) || (state == DROP)) && !IMemRValid_i) ? DROP : IDLE;
         skid_v         <= 1'b0;
         skid_instr     <= 32'h0;
         skid_pc        <= 32'h0;
         ValidF_o       <= 1'b0;
         InstructionF_o <= 32'h0;
         PCF_o          <= 32'h0;
         PCPlus4F_o     <= 32'h0;
      end else begin
         if (PCSrcE_i) begin
            fpc <= PCTargetE_i & ~32'h3;
         end else if (req_fire) begin
            fpc    <= fpc + 32'd4;
            req_pc <= fpc;
         end

         case (state)
            IDLE: if (req_fire) state <= WAIT;
            WAIT: begin
               if (PCSrcE_i)
                  state <= IMemRValid_i ? IDLE : DROP;
               else if (IMemRValid_i)
                  state <= req_fire ? WAIT : IDLE;
            end
            DROP: if (IMemRValid_i) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (PCSrcE_i) begin
            ValidF_o <= 1'b0;
            skid_v   <= 1'b0;
         end else if (!StallF_i) begin
            if (skid_v) begin
               InstructionF_o <= skid_instr;
               PCF_o          <= skid_pc;
               PCPlus4F_o     <= skid_pc + 32'd4;
               ValidF_o       <= 1'b1;
               skid_v         <= rsp_take;
               if (rsp_take) begin
                  skid_instr <= IMemRData_i;
                  skid_pc    <= req_pc;
               end
            end else if (rsp_take) begin
               InstructionF_o <= IMemRData_i;
               PCF_o          <= req_pc;
               PCPlus4F_o     <= req_pc + 32'd4;
               ValidF_o       <= 1'b1;
            end else begin
               ValidF_o <= 1'b0;
            end
         end else if (rsp_take) begin
            if (!ValidF_o) begin
               InstructionF_o <= IMemRData_i;
               PCF_o          <= req_pc;
               PCPlus4F_o     <= req_pc + 32'd4;
               ValidF_o       <= 1'b1;
            end else begin
               skid_instr <= IMemRData_i;
               skid_pc    <= req_pc;
               skid_v     <= 1'b1;
            end
         end
      end
   end

endmodule
